// File: rtl/decod_pkg.sv
// Shared types and helpers for the 16-to-4 sequential request encoder.
package decod_pkg;
  localparam int unsigned N_LINES = 16;
  localparam int unsigned CODE_W  = 4;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [N_LINES-1:0] req_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  // Rotate right by n: result[j] = v[(j+n) mod 16].
  function automatic req_t rotr16(input req_t v, input code_t n);
    logic [2*N_LINES-1:0] d;
    d = {v, v} >> n;
    return d[N_LINES-1:0];
  endfunction
endpackage

// File: rtl/prio_enc16.sv
// Combinational priority encoder: highest set bit searching downward from
// start, wrapping modulo 16.
module prio_enc16
  import decod_pkg::*;
(
  input  req_t  vec,
  input  code_t start,
  output code_t code,
  output logic  any
);
  req_t  rot;
  code_t hi;

  // Rotate so that bit 'start' lands on bit 15, take the top bit, rotate back.
  always_comb begin
    rot = rotr16(vec, start + 4'd1);
    hi  = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (rot[i]) hi = code_t'(i);
    end
    code = hi + start + 4'd1;
    any  = |vec;
  end
endmodule

// File: rtl/decod_enc16.sv
// Sequential 16-to-4 request encoder: sticky pending set served one code at
// a time on a valid/ready channel, fixed or round-robin priority.
module decod_enc16
  import decod_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  req_t  req,
  output code_t out_code,
  output logic  out_e,
  output logic  out_valid,
  input  logic  out_ready,
  output req_t  pend,
  output logic  busy
);
  state_t state;
  code_t  last;
  logic   served;
  req_t   cand;
  logic   slot_free;
  code_t  start;
  code_t  k;
  logic   any;

  assign out_valid = (state == S_HOLD);
  assign out_e     = out_valid;
  assign busy      = (|pend) | out_valid;
  assign cand      = pend | (en ? req : '0);
  assign slot_free = !out_valid || out_ready;

  // Until the first load the search includes the reset pointer itself,
  // so a full request set from reset is served 15 down to 0.
  assign start = (RR && served) ? last - 4'd1 : 4'hF;

  prio_enc16 u_prio (
    .vec   (cand),
    .start (start),
    .code  (k),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      out_code <= '0;
      pend     <= '0;
      last     <= 4'hF;
      served   <= 1'b0;
    end else if (slot_free) begin
      if (any) begin
        state    <= S_HOLD;
        out_code <= k;
        pend     <= cand & ~(req_t'(1) << k);
        last     <= k;
        served   <= 1'b1;
      end else begin
        state <= S_EMPTY;
        pend  <= '0;
      end
    end else begin
      pend <= cand;
    end
  end
endmodule

// File: tb/tb_decod_enc16.sv
// Bench for decod_enc16: fixed-priority and round-robin instances share
// stimulus and are compared against a behavioural model plus directed values.
module tb_decod_enc16;
  import decod_pkg::*;

  typedef struct packed {
    req_t  pend;
    logic  valid;
    code_t code;
    code_t last;
    logic  first;
  } mstate_t;

  logic  clk;
  logic  rst_n;
  logic  en;
  req_t  req;
  logic  out_ready;
  code_t out_code [2];
  logic  out_e    [2];
  logic  out_valid[2];
  req_t  pend     [2];
  logic  busy     [2];

  mstate_t     m[2];
  logic [22:0] obs[2];
  logic [22:0] exp_v[2];

  int checks;
  int passed;

  decod_enc16 #(.RR(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .out_code(out_code[0]), .out_e(out_e[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .pend(pend[0]), .busy(busy[0])
  );

  decod_enc16 #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .out_code(out_code[1]), .out_e(out_e[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .pend(pend[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: walk the 16 indices downward from the starting point and serve
  // the first one that is requested.
  function automatic mstate_t model_next(mstate_t s, bit rr, bit rst, bit e,
                                         req_t r, bit rdy);
    mstate_t n;
    req_t    cand;
    int      start;
    int      k;
    n = s;
    if (!rst) begin
      n.pend = '0; n.valid = 1'b0; n.code = '0; n.last = 4'hF; n.first = 1'b1;
      return n;
    end
    cand = s.pend | (e ? r : 16'h0000);
    if (s.valid && !rdy) begin
      n.pend = cand;
      return n;
    end
    start = (rr && !s.first) ? (int'(s.last) + 15) % 16 : 15;
    k = -1;
    for (int off = 0; off < 16; off++) begin
      if (k < 0 && cand[(start - off + 16) % 16]) k = (start - off + 16) % 16;
    end
    if (k < 0) begin
      n.valid = 1'b0;
      n.pend  = '0;
    end else begin
      n.valid   = 1'b1;
      n.code    = code_t'(k);
      n.pend    = cand;
      n.pend[k] = 1'b0;
      n.last    = code_t'(k);
      n.first   = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= model_next(m[0], 1'b0, rst_n, en, req, out_ready);
    m[1] <= model_next(m[1], 1'b1, rst_n, en, req, out_ready);
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      obs[d]   = {out_code[d], out_valid[d], out_e[d], busy[d], pend[d]};
      exp_v[d] = {m[d].code, m[d].valid, m[d].valid,
                  (|m[d].pend) | m[d].valid, m[d].pend};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 16'h0000; out_ready = 1'b1;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 23'h0)
        $display("FAIL reset_values dut%0d: got %h expected %h", d, obs[d], 23'h0);
      else passed++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({out_valid[d], busy[d]} !== 2'b00 || obs[d] !== exp_v[d])
          $display("FAIL idle dut%0d cycle %0d: got %h expected %h", d, c, obs[d], exp_v[d]);
        else passed++;
      end
    end
    req = 16'h8000;
    tick();
    req = 16'h0000;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_code[d] !== 4'hF || out_e[d] !== 1'b1 || obs[d] !== exp_v[d])
        $display("FAIL first_code dut%0d: got code %h e %b expected code f e 1", d, out_code[d], out_e[d]);
      else passed++;
    end
    tick();
  endtask

  task automatic test_pair();
    code_t want[2];
    want[0] = 4'h4; want[1] = 4'h0;
    req = 16'h0011; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      req = 16'h0000;
      checks++;
      if (c < 2 ? (out_code[0] !== want[c] || out_valid[0] !== 1'b1)
                : (out_valid[0] !== 1'b0 || pend[0] !== 16'h0000))
        $display("FAIL pair step %0d: got code %h valid %b pend %h", c, out_code[0], out_valid[0], pend[0]);
      else passed++;
      checks++;
      if (obs[1] !== exp_v[1])
        $display("FAIL pair_rr step %0d: got %h expected %h", c, obs[1], exp_v[1]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    req = 16'h0003; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      req = 16'h0000;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (out_code[d] !== 4'h1 || out_valid[d] !== 1'b1 || pend[d] !== 16'h0001)
          $display("FAIL stall dut%0d cycle %0d: got code %h valid %b pend %h expected code 1 valid 1 pend 0001",
                   d, c, out_code[d], out_valid[d], pend[d]);
        else passed++;
      end
    end
    out_ready = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_code[d] !== 4'h0 || out_valid[d] !== 1'b1 || pend[d] !== 16'h0000)
        $display("FAIL stall_release dut%0d: got code %h valid %b expected code 0 valid 1", d, out_code[d], out_valid[d]);
      else passed++;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || obs[d] !== exp_v[d])
        $display("FAIL stall_drain dut%0d: got %h expected %h", d, obs[d], exp_v[d]);
      else passed++;
    end
  endtask

  task automatic test_rr_full();
    int hits[16];
    int starved;
    for (int i = 0; i < 16; i++) hits[i] = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 16'hFFFF; out_ready = 1'b1; en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      hits[out_code[1]]++;
      checks++;
      if (out_code[1] !== code_t'(15 - (c % 16)) || out_valid[1] !== 1'b1)
        $display("FAIL rr_full cycle %0d: got %h expected %h", c, out_code[1], 4'(15 - (c % 16)));
      else passed++;
      checks++;
      if (out_code[0] !== 4'hF || obs[0] !== exp_v[0])
        $display("FAIL fixed_full cycle %0d: got %h expected %h", c, obs[0], exp_v[0]);
      else passed++;
    end
    starved = 0;
    for (int i = 0; i < 16; i++) if (hits[i] < 2) starved++;
    checks++;
    if (starved != 0)
      $display("FAIL rr_starve: got %0d starved indices expected 0", starved);
    else passed++;
    req = 16'h0000;
    for (int c = 0; c < 20; c++) tick();
  endtask

  task automatic test_enable();
    en = 1'b0; req = 16'h0100; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (out_valid[d] !== 1'b0 || pend[d] !== 16'h0000)
          $display("FAIL en_mask dut%0d cycle %0d: got valid %b pend %h expected 0 0000", d, c, out_valid[d], pend[d]);
        else passed++;
      end
    end
    en = 1'b1;
    tick();
    req = 16'h0000;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_code[d] !== 4'h8 || out_valid[d] !== 1'b1)
        $display("FAIL en_open dut%0d: got code %h valid %b expected 8 1", d, out_code[d], out_valid[d]);
      else passed++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req = 16'h01F0; out_ready = 1'b0;
    tick();
    req = 16'h0000;
    tick();
    checks++;
    if (out_code[0] !== 4'h8 || out_valid[0] !== 1'b1 || pend[0] !== 16'h00F0)
      $display("FAIL pre_reset: got code %h valid %b pend %h expected 8 1 00f0", out_code[0], out_valid[0], pend[0]);
    else passed++;
    rst_n = 1'b0; req = 16'hFFFF;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== 23'h0)
        $display("FAIL mid_reset dut%0d: got %h expected %h", d, obs[d], 23'h0);
      else passed++;
    end
    rst_n = 1'b1; req = 16'h0000; out_ready = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0)
        $display("FAIL post_reset dut%0d: got valid %b busy %b expected 0 0", d, out_valid[d], busy[d]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req       = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0000;
      en        = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 80) != 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_v[d])
          $display("FAIL random dut%0d cycle %0d: got %h expected %h", d, c, obs[d], exp_v[d]);
        else passed++;
      end
    end
    rst_n = 1'b1; req = 16'h0000; en = 1'b1; out_ready = 1'b1;
  endtask

  initial begin
    checks = 0; passed = 0;
    rst_n = 1'b0; en = 1'b1; req = 16'h0000; out_ready = 1'b1;
    test_reset();
    test_pair();
    test_stall();
    test_rr_full();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
